// File: rtl/controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller side is master; the datapath side is slave.
interface controller_if;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUControl;
    logic [3:0]  State;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
        output ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, State
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
        input  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, State
    );
endinterface

// File: rtl/controller.sv
// Multicycle ARM-subset control unit: FSM sequencing, ALU decode,
// NZCV flag storage and condition evaluation.
module controller (
    input  logic         clk,
    input  logic         reset,
    controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       condexr_q, condexr_d;
    logic       condex;
    logic [1:0] flagw;
    logic [1:0] alu_ctl;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic       rd_pc;
    logic       n, z, c, v;

    assign cond  = bus.Instr[31:28];
    assign op    = bus.Instr[27:26];
    assign funct = bus.Instr[25:20];
    assign rd_pc = (bus.Instr[15:12] == 4'hF);
    assign {n, z, c, v} = flags_q;

    // State, stored flags and latched condition result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            flags_q   <= 4'b0000;
            condexr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            condexr_q <= condexr_d;
        end
    end

    // Condition code evaluation against the stored flags.
    always_comb begin
        condex = 1'b1;
        case (cond)
            4'b0000: condex = z;
            4'b0001: condex = ~z;
            4'b0010: condex = c;
            4'b0011: condex = ~c;
            4'b0100: condex = n;
            4'b0101: condex = ~n;
            4'b0110: condex = v;
            4'b0111: condex = ~v;
            4'b1000: condex = c & ~z;
            4'b1001: condex = ~c | z;
            4'b1010: condex = (n == v);
            4'b1011: condex = (n != v);
            4'b1100: condex = ~z & (n == v);
            4'b1101: condex = z | (n != v);
            default: condex = 1'b1;
        endcase
    end

    // ALU command decode; unknown commands add without touching flags.
    always_comb begin
        alu_ctl = 2'b00;
        flagw   = 2'b00;
        case (funct[4:1])
            4'b0100: begin alu_ctl = 2'b00; flagw = 2'b11; end
            4'b0010: begin alu_ctl = 2'b01; flagw = 2'b11; end
            4'b0000: begin alu_ctl = 2'b10; flagw = 2'b10; end
            4'b1100: begin alu_ctl = 2'b11; flagw = 2'b10; end
            default: begin alu_ctl = 2'b00; flagw = 2'b00; end
        endcase
        if (!funct[0])
            flagw = 2'b00;
    end

    // Condition latch at end of DECODE; flag update at end of EXECUTE.
    always_comb begin
        condexr_d = condexr_q;
        flags_d   = flags_q;
        if (state_q == DECODE)
            condexr_d = condex;
        if ((state_q == EXECUTER || state_q == EXECUTEI) && condexr_q) begin
            if (flagw[1]) flags_d[3:2] = bus.ALUFlags[3:2];
            if (flagw[0]) flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_d        = FETCH;
        bus.PCWrite    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.ALUControl = 2'b00;
        case (state_q)
            FETCH: begin
                state_d       = DECODE;
                bus.IRWrite   = 1'b1;
                bus.PCWrite   = 1'b1;
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            DECODE: begin
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                case (op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                state_d     = funct[0] ? MEMRD : MEMWR;
                bus.ALUSrcB = 2'b01;
            end
            MEMRD: begin
                state_d    = MEMWB;
                bus.AdrSrc = 1'b1;
            end
            MEMWR: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = condexr_q;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = condexr_q;
                bus.PCWrite   = condexr_q & rd_pc;
            end
            EXECUTER: begin
                state_d        = ALUWB;
                bus.ALUControl = alu_ctl;
            end
            EXECUTEI: begin
                state_d        = ALUWB;
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = alu_ctl;
            end
            ALUWB: begin
                bus.RegWrite = condexr_q;
                bus.PCWrite  = condexr_q & rd_pc;
            end
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.PCWrite   = condexr_q;
            end
            default: state_d = FETCH;
        endcase
    end

    // Instruction-field decode valid in every state.
    always_comb begin
        bus.ImmSrc    = op;
        bus.RegSrc[0] = (op == 2'b10);
        bus.RegSrc[1] = (op == 2'b01) & ~funct[0];
        bus.State     = state_q;
    end
endmodule

// File: tb/tb_controller.sv
// Directed testbench for the multicycle controller.
// Expected values are hand-computed per instruction and state.
module tb_controller;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    controller_if bus ();

    controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.Instr = 32'h0;
        bus.ALUFlags = 4'h0;
        #3;
        tests++; if (bus.State !== 4'd0) begin fails++; $display("FAIL rst_state got %0d exp 0", bus.State); end
        tests++; if (bus.PCWrite !== 1'b1) begin fails++; $display("FAIL rst_pcw got %0b exp 1", bus.PCWrite); end
        tests++; if (bus.IRWrite !== 1'b1) begin fails++; $display("FAIL rst_irw got %0b exp 1", bus.IRWrite); end
        tests++; if ({bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc} !== 6'b011010) begin fails++; $display("FAIL rst_sel got %b exp 011010", {bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc}); end
        tests++; if ({bus.MemWrite, bus.RegWrite} !== 2'b00) begin fails++; $display("FAIL rst_wr got %b exp 00", {bus.MemWrite, bus.RegWrite}); end
        tests++; if (dut.flags_q !== 4'b0000) begin fails++; $display("FAIL rst_flags got %b exp 0000", dut.flags_q); end
        tests++; if (dut.condexr_q !== 1'b0) begin fails++; $display("FAIL rst_condexr got %b exp 0", dut.condexr_q); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++; if (bus.State !== 4'd0) begin fails++; $display("FAIL rst_first got %0d exp 0", bus.State); end
    endtask

    task automatic test_adds(input logic [3:0] alu_f, input logic [3:0] exp_f);
        bus.Instr = 32'hE2921005;
        bus.ALUFlags = alu_f;
        tests++; if (bus.State !== 4'd0 || bus.RegWrite !== 1'b0) begin fails++; $display("FAIL adds_s0 got %0d/%b exp 0/0", bus.State, bus.RegWrite); end
        step;
        tests++; if (bus.State !== 4'd1 || bus.RegWrite !== 1'b0) begin fails++; $display("FAIL adds_s1 got %0d/%b exp 1/0", bus.State, bus.RegWrite); end
        step;
        tests++; if (bus.State !== 4'd7 || bus.ALUControl !== 2'b00 || bus.ALUSrcB !== 2'b01) begin fails++; $display("FAIL adds_s7 got %0d/%b/%b exp 7/00/01", bus.State, bus.ALUControl, bus.ALUSrcB); end
        tests++; if (bus.RegWrite !== 1'b0) begin fails++; $display("FAIL adds_rw7 got %b exp 0", bus.RegWrite); end
        step;
        tests++; if (bus.State !== 4'd8 || bus.RegWrite !== 1'b1 || bus.PCWrite !== 1'b0) begin fails++; $display("FAIL adds_s8 got %0d/%b/%b exp 8/1/0", bus.State, bus.RegWrite, bus.PCWrite); end
        tests++; if (dut.flags_q !== exp_f) begin fails++; $display("FAIL adds_flags got %b exp %b", dut.flags_q, exp_f); end
        step;
        tests++; if (bus.State !== 4'd0) begin fails++; $display("FAIL adds_end got %0d exp 0", bus.State); end
    endtask

    task automatic test_beq(input logic exp_pcw);
        bus.Instr = 32'h0A000002;
        step;
        tests++; if (bus.State !== 4'd1) begin fails++; $display("FAIL beq_s1 got %0d exp 1", bus.State); end
        step;
        tests++; if (bus.State !== 4'd9 || bus.PCWrite !== exp_pcw) begin fails++; $display("FAIL beq_s9 got %0d/%b exp 9/%b", bus.State, bus.PCWrite, exp_pcw); end
        tests++; if (bus.ImmSrc !== 2'b10 || bus.RegSrc !== 2'b01) begin fails++; $display("FAIL beq_dec got %b/%b exp 10/01", bus.ImmSrc, bus.RegSrc); end
        step;
        tests++; if (bus.State !== 4'd0) begin fails++; $display("FAIL beq_end got %0d exp 0", bus.State); end
    endtask

    task automatic test_ldr;
        bus.Instr = 32'hE5921000;
        step;
        step;
        tests++; if (bus.State !== 4'd2 || bus.ALUSrcB !== 2'b01 || bus.ImmSrc !== 2'b01) begin fails++; $display("FAIL ldr_s2 got %0d/%b/%b exp 2/01/01", bus.State, bus.ALUSrcB, bus.ImmSrc); end
        step;
        tests++; if (bus.State !== 4'd3 || bus.AdrSrc !== 1'b1 || bus.RegSrc !== 2'b00) begin fails++; $display("FAIL ldr_s3 got %0d/%b/%b exp 3/1/00", bus.State, bus.AdrSrc, bus.RegSrc); end
        step;
        tests++; if (bus.State !== 4'd4 || bus.ResultSrc !== 2'b01 || bus.RegWrite !== 1'b1) begin fails++; $display("FAIL ldr_s4 got %0d/%b/%b exp 4/01/1", bus.State, bus.ResultSrc, bus.RegWrite); end
        tests++; if (bus.PCWrite !== 1'b0 || bus.MemWrite !== 1'b0) begin fails++; $display("FAIL ldr_s4w got %b/%b exp 0/0", bus.PCWrite, bus.MemWrite); end
        step;
        tests++; if (bus.State !== 4'd0) begin fails++; $display("FAIL ldr_end got %0d exp 0", bus.State); end
    endtask

    task automatic test_str;
        bus.Instr = 32'hE5821000;
        step;
        step;
        tests++; if (bus.State !== 4'd2) begin fails++; $display("FAIL str_s2 got %0d exp 2", bus.State); end
        step;
        tests++; if (bus.State !== 4'd5 || bus.MemWrite !== 1'b1 || bus.RegSrc !== 2'b10) begin fails++; $display("FAIL str_s5 got %0d/%b/%b exp 5/1/10", bus.State, bus.MemWrite, bus.RegSrc); end
        tests++; if (bus.RegWrite !== 1'b0 || bus.AdrSrc !== 1'b1) begin fails++; $display("FAIL str_s5b got %b/%b exp 0/1", bus.RegWrite, bus.AdrSrc); end
        step;
        tests++; if (bus.State !== 4'd0) begin fails++; $display("FAIL str_end got %0d exp 0", bus.State); end
    endtask

    task automatic test_subnes;
        bus.Instr = 32'h12533001;
        bus.ALUFlags = 4'b0000;
        step;
        step;
        tests++; if (bus.State !== 4'd7 || bus.ALUControl !== 2'b01) begin fails++; $display("FAIL subnes_s7 got %0d/%b exp 7/01", bus.State, bus.ALUControl); end
        step;
        tests++; if (bus.State !== 4'd8 || bus.RegWrite !== 1'b0) begin fails++; $display("FAIL subnes_s8 got %0d/%b exp 8/0", bus.State, bus.RegWrite); end
        tests++; if (dut.flags_q !== 4'b0100) begin fails++; $display("FAIL subnes_flags got %b exp 0100", dut.flags_q); end
        step;
    endtask

    task automatic test_orrs;
        bus.Instr = 32'hE1921003;
        bus.ALUFlags = 4'b1011;
        step;
        step;
        tests++; if (bus.State !== 4'd6 || bus.ALUControl !== 2'b11 || bus.ALUSrcB !== 2'b00) begin fails++; $display("FAIL orrs_s6 got %0d/%b/%b exp 6/11/00", bus.State, bus.ALUControl, bus.ALUSrcB); end
        step;
        tests++; if (dut.flags_q !== 4'b1000) begin fails++; $display("FAIL orrs_flags got %b exp 1000", dut.flags_q); end
        step;
    endtask

    task automatic test_add_pc;
        bus.Instr = 32'hE282F004;
        bus.ALUFlags = 4'b0110;
        step;
        step;
        step;
        tests++; if (bus.State !== 4'd8 || bus.PCWrite !== 1'b1 || bus.RegWrite !== 1'b1) begin fails++; $display("FAIL addpc_s8 got %0d/%b/%b exp 8/1/1", bus.State, bus.PCWrite, bus.RegWrite); end
        tests++; if (dut.flags_q !== 4'b1000) begin fails++; $display("FAIL addpc_flags got %b exp 1000", dut.flags_q); end
        step;
    endtask

    task automatic test_undef;
        bus.Instr = 32'hEC000000;
        step;
        tests++; if (bus.State !== 4'd1 || {bus.PCWrite, bus.RegWrite, bus.MemWrite} !== 3'b000) begin fails++; $display("FAIL undef_s1 got %0d/%b exp 1/000", bus.State, {bus.PCWrite, bus.RegWrite, bus.MemWrite}); end
        step;
        tests++; if (bus.State !== 4'd0) begin fails++; $display("FAIL undef_end got %0d exp 0", bus.State); end
    endtask

    task automatic test_reset_mid;
        bus.Instr = 32'hE5921000;
        step;
        step;
        step;
        tests++; if (bus.State !== 4'd3) begin fails++; $display("FAIL rmid_pre got %0d exp 3", bus.State); end
        reset = 1'b1;
        #1;
        tests++; if (bus.State !== 4'd0 || bus.PCWrite !== 1'b1 || bus.IRWrite !== 1'b1) begin fails++; $display("FAIL rmid_state got %0d/%b/%b exp 0/1/1", bus.State, bus.PCWrite, bus.IRWrite); end
        tests++; if ({bus.RegWrite, bus.MemWrite, bus.AdrSrc} !== 3'b000) begin fails++; $display("FAIL rmid_wr got %b exp 000", {bus.RegWrite, bus.MemWrite, bus.AdrSrc}); end
        tests++; if (dut.flags_q !== 4'b0000) begin fails++; $display("FAIL rmid_flags got %b exp 0000", dut.flags_q); end
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset;
        test_adds(4'b0100, 4'b0100);
        test_beq(1'b1);
        test_adds(4'b0000, 4'b0000);
        test_beq(1'b0);
        test_ldr;
        test_str;
        test_adds(4'b0100, 4'b0100);
        test_subnes;
        test_orrs;
        test_add_pc;
        test_undef;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/controller.md
# controller

Multicycle control unit for the ARM-subset processor: sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every select and enable on the multicycle datapath and the data-memory write enable. It holds the architectural NZCV flags and evaluates condition codes. It sits directly upstream of the datapath: it consumes `Instr`/`ALUFlags` from the datapath and returns the control bundle.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces FETCH and clears flags.
- `Instr`  in  32  instruction register contents. Fields used:
  - `[31:28]` Cond
  - `[27:26]` Op
  - `[25:20]` Funct
  - `[15:12]` Rd
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU, current cycle.
- `PCWrite`  out  1  PC register enable.
- `MemWrite`  out  1  data memory write enable.
- `RegWrite`  out  1  register file write enable.
- `IRWrite`  out  1  instruction register enable.
- `AdrSrc`  out  1  address select: 0 = PC, 1 = Result.
- `RegSrc`  out  2  [0]: RA1 = R15; [1]: RA2 = Rd.
- `ALUSrcA`  out  2  operand A select: 00 = A, 01 = PC, 10 = ALUOut.
- `ALUSrcB`  out  2  operand B select: 00 = WriteData, 01 = ExtImm, 10 = constant 4.
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ImmSrc`  out  2  immediate format: 00 = DP imm8, 01 = mem imm12, 10 = branch imm24.
- `ALUControl`  out  2  ALU operation: 00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- `State`  out  4  current FSM state, for debug and verification.

## Operation

**State encoding**
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXECUTER = 6, EXECUTEI = 7, ALUWB = 8, BRANCH = 9.
- Codes 10–15 are unreachable; if entered, return to FETCH on the next edge.

**Transitions**
- FETCH → DECODE.
- DECODE, by Op:
  - Op = 01 → MEMADR.
  - Op = 00 → EXECUTEI if Funct[5] = 1, else EXECUTER.
  - Op = 10 → BRANCH.
  - Op = 11 (undefined) → FETCH, with no side effects.
- MEMADR → MEMRD if Funct[0] = 1 (load); → MEMWR otherwise.
- MEMRD → MEMWB.
- EXECUTER and EXECUTEI → ALUWB.
- MEMWB, MEMWR, ALUWB and BRANCH → FETCH.

**Outputs per state** (any output not listed is 0; `ALUControl` defaults to 00)
- FETCH: IRWrite = 1, PCWrite = 1, AdrSrc = 0, ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10.
- DECODE: ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10.
- MEMADR: ALUSrcA = 00, ALUSrcB = 01.
- MEMRD: AdrSrc = 1, ResultSrc = 00.
- MEMWR: AdrSrc = 1, ResultSrc = 00, MemWrite = CondExR.
- MEMWB: ResultSrc = 01, RegWrite = CondExR, PCWrite = CondExR & (Rd == 15).
- EXECUTER: ALUSrcA = 00, ALUSrcB = 00, ALUControl decoded from the command field.
- EXECUTEI: ALUSrcA = 00, ALUSrcB = 01, ALUControl decoded from the command field.
- ALUWB: ResultSrc = 00, RegWrite = CondExR, PCWrite = CondExR & (Rd == 15).
- BRANCH: ALUSrcA = 00, ALUSrcB = 01, ResultSrc = 10, PCWrite = CondExR.

**Decoded in every state** (combinational from `Instr`)
- ImmSrc = Op.
- RegSrc[0] = (Op == 10).
- RegSrc[1] = (Op == 01) & ~Funct[0].

**ALU decode** (command field Funct[4:1], S bit = Funct[0])
- 0100 → ALUControl 00 (ADD), FlagW = 11.
- 0010 → ALUControl 01 (SUB), FlagW = 11.
- 0000 → ALUControl 10 (AND), FlagW = 10.
- 1100 → ALUControl 11 (ORR), FlagW = 10.
- FlagW is forced to 00 when S = 0.
- Any other command → ALUControl 00, FlagW = 00, writeback still proceeds.

**Condition logic**
- CondEx is evaluated from Cond and the stored Flags over the full ARM set EQ…LE.
- AL (1110) and 1111 both evaluate true.
- CondExR is a register loaded with CondEx at the end of DECODE.
- Flags update at the end of EXECUTER/EXECUTEI, only when CondExR = 1:
  - Flags[3:2] ← ALUFlags[3:2] when FlagW[1] = 1.
  - Flags[1:0] ← ALUFlags[1:0] when FlagW[0] = 1.

## Timing
- All outputs are combinational from State, `Instr` and CondExR; there are no registered outputs.
- Latency per instruction class:
  - Branch: 3 cycles.
  - DP and STR: 4 cycles.
  - LDR: 5 cycles.
  - Undefined: 2 cycles.
- During reset and the first cycle after it, outputs show FETCH values:
  - PCWrite = 1, IRWrite = 1, ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10, State = 0.
  - Flags = 0000, CondExR = 0, MemWrite = 0, RegWrite = 0.
- Reset asserted mid-instruction:
  - State goes to FETCH immediately, without waiting for `clk`.
  - The in-flight RegWrite/MemWrite drop in the same cycle.
- Flags written in EXECUTE are visible to the condition logic of the next instruction's DECODE.
- `Instr` must be stable from the DECODE cycle through the instruction's last state; IRWrite is high only in FETCH, so the datapath guarantees this.

## Test plan
- **Reset:** assert `reset` mid-MEMRD → State = 0 the same cycle, outputs equal the FETCH values above, Flags = 0000.
- **ADDS R1,R2,#5** (0xE2921005), `ALUFlags` = 0100 during EXECUTEI:
  - State sequence 0, 1, 7, 8.
  - ALUControl = 00 in state 7.
  - Flags = 0100 afterwards.
  - RegWrite = 1 only in state 8.
- **BEQ** (0x0A000002):
  - Z = 1 → BRANCH with PCWrite = 1, ImmSrc = 10, RegSrc = 01.
  - Z = 0 → PCWrite = 0 in BRANCH.
- **LDR R1,[R2]** (0xE5921000): states 0, 1, 2, 3, 4; AdrSrc = 1 in state 3; ResultSrc = 01 and RegWrite = 1 in state 4.
- **STR R1,[R2]** (0xE5821000): states 0, 1, 2, 5; MemWrite = 1 and RegSrc = 10 in state 5.
- **SUBNES R3,R3,#1** (0x12533001) with Z = 1:
  - ALUWB has RegWrite = 0; Flags unchanged.
  - Op = 11 word → states 0, 1, 0 with no writes.
